s08_bus_arbiter: RTL and testbench

Two-requester arbiter for the MiniS08 single-port memory/IO bus (10-bit address, 8-bit data, covering SCI, RAM and ROM regions). It shares that bus between the CPU and a serial monitor/loader that downloads programs into RAM and inspects memory while the CPU runs. Each requester gets whole bus transactions with a request/acknowledge handshake. Arbitration is round-robin, with a bounded lock so monitor bursts cannot starve the CPU. The block sits between both requesters and the existing address/data decode in the `clk50` domain.

---
 rtl/s08_bus_pkg.sv | 32 +++
 rtl/s08_rr_pick.sv | 38 +++
 rtl/s08_bus_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_s08_bus_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s08_bus_pkg.sv
// ============================================================================
// Module      : s08_bus_pkg
// Description : Shared widths, FSM encodings and owner IDs for the MiniS08
//               two-requester bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package s08_bus_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ACCESS = 2'd1;
  localparam state_t ST_WAIT   = 2'd2;
  localparam state_t ST_ACK    = 2'd3;

  localparam logic ID_CPU = 1'b0;
  localparam logic ID_MON = 1'b1;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } bus_req_t;

endpackage

`default_nettype wire

// File: rtl/s08_rr_pick.sv
// ============================================================================
// Module      : s08_rr_pick
// Description : Combinational two-way round-robin pick with bounded monitor
//               lock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module s08_rr_pick
  import s08_bus_pkg::*;
(
  input  logic cpu_req,
  input  logic mon_req,
  input  logic last_gnt,
  input  logic mon_lock,
  input  logic hold_max,
  output logic grant_valid,
  output logic grant_id
);

  always_comb begin
    grant_valid = cpu_req | mon_req;
    grant_id    = ID_CPU;
    if (cpu_req && mon_req) begin
      // Lock only extends a monitor run; once the run hits its bound the CPU goes in.
      if (last_gnt == ID_MON) begin
        grant_id = (mon_lock && !hold_max) ? ID_MON : ID_CPU;
      end else begin
        grant_id = ID_MON;
      end
    end else if (mon_req) begin
      grant_id = ID_MON;
    end
  end

endmodule

`default_nettype wire

// File: rtl/s08_bus_arbiter.sv
// ============================================================================
// Module      : s08_bus_arbiter
// Description : Shares the MiniS08 memory/IO bus between the CPU and the serial
//               monitor, one whole transaction per grant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module s08_bus_arbiter
  import s08_bus_pkg::*;
#(
  parameter int MEM_LAT  = 1,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk50,
  input  logic              resetin,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              mon_req,
  input  logic              mon_we,
  input  logic [ADDR_W-1:0] mon_addr,
  input  logic [DATA_W-1:0] mon_wdata,
  output logic              mon_ack,
  output logic [DATA_W-1:0] mon_rdata,
  input  logic              mon_lock,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              gnt_id,
  output logic              busy
);

  localparam int                HOLD_W   = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_TOP = HOLD_W'(MAX_HOLD);
  localparam logic [1:0]        LAT_M1   = 2'(MEM_LAT - 1);

  state_t              state_q,     state_d;
  logic [1:0]          cnt_q,       cnt_d;
  logic                owner_q,     owner_d;
  bus_req_t            txn_q,       txn_d;
  logic                mem_we_q,    mem_we_d;
  logic                mem_re_q,    mem_re_d;
  logic                cpu_ack_q,   cpu_ack_d;
  logic                mon_ack_q,   mon_ack_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   mon_rdata_q, mon_rdata_d;
  logic                last_gnt_q,  last_gnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q,  hold_cnt_d;
  logic                busy_q,      busy_d;

  logic                grant_valid;
  logic                grant_id;
  bus_req_t            sel_req;

  s08_rr_pick u_pick (
    .cpu_req     (cpu_req),
    .mon_req     (mon_req),
    .last_gnt    (last_gnt_q),
    .mon_lock    (mon_lock),
    .hold_max    (hold_cnt_q == HOLD_TOP),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_comb begin
    sel_req = (grant_id == ID_MON) ? bus_req_t'{mon_we, mon_addr, mon_wdata}
                                   : bus_req_t'{cpu_we, cpu_addr, cpu_wdata};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    txn_d       = txn_q;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    cpu_ack_d   = 1'b0;
    mon_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    mon_rdata_d = mon_rdata_q;
    last_gnt_d  = last_gnt_q;
    hold_cnt_d  = hold_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d    = ST_ACCESS;
          owner_d    = grant_id;
          txn_d      = sel_req;
          mem_we_d   = sel_req.we;
          mem_re_d   = ~sel_req.we;
          last_gnt_d = grant_id;
          // The run length only grows while the CPU is actually being held off.
          if (!cpu_req || grant_id == ID_CPU || !mon_lock) begin
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          end
        end
      end
      ST_ACCESS: begin
        state_d = ST_WAIT;
        cnt_d   = LAT_M1;
      end
      ST_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = ST_ACK;
          if (owner_q == ID_MON) begin
            mon_ack_d = 1'b1;
            if (!txn_q.we) mon_rdata_d = mem_rdata;
          end else begin
            cpu_ack_d = 1'b1;
            if (!txn_q.we) cpu_rdata_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk50 or negedge resetin) begin
    if (!resetin) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      owner_q     <= ID_CPU;
      txn_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      mon_ack_q   <= 1'b0;
      cpu_rdata_q <= '0;
      mon_rdata_q <= '0;
      last_gnt_q  <= ID_MON;
      hold_cnt_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      owner_q     <= owner_d;
      txn_q       <= txn_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      cpu_ack_q   <= cpu_ack_d;
      mon_ack_q   <= mon_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      mon_rdata_q <= mon_rdata_d;
      last_gnt_q  <= last_gnt_d;
      hold_cnt_q  <= hold_cnt_d;
      busy_q      <= busy_d;
    end
  end

  assign mem_addr  = txn_q.addr;
  assign mem_wdata = txn_q.wdata;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign cpu_ack   = cpu_ack_q;
  assign mon_ack   = mon_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mon_rdata = mon_rdata_q;
  assign gnt_id    = owner_q;
  assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_s08_bus_arbiter.sv
// ============================================================================
// Module      : tb_s08_bus_arbiter
// Description : Directed self-checking bench for s08_bus_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_s08_bus_arbiter;

  logic       clk50 = 1'b0;
  logic       resetin;
  logic       cpu_req, cpu_we, mon_req, mon_we, mon_lock;
  logic [9:0] cpu_addr, mon_addr;
  logic [7:0] cpu_wdata, mon_wdata, mem_rdata;

  logic       a_cpu_ack, a_mon_ack, a_mem_we, a_mem_re, a_gnt_id, a_busy;
  logic [7:0] a_cpu_rdata, a_mon_rdata, a_mem_wdata;
  logic [9:0] a_mem_addr;
  logic       b_cpu_ack, b_mon_ack, b_mem_we, b_mem_re, b_gnt_id, b_busy;
  logic [7:0] b_cpu_rdata, b_mon_rdata, b_mem_wdata;
  logic [9:0] b_mem_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk50 = ~clk50;

  s08_bus_arbiter #(.MEM_LAT(1), .MAX_HOLD(4)) dut_a (
    .clk50(clk50), .resetin(resetin),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(a_cpu_ack), .cpu_rdata(a_cpu_rdata),
    .mon_req(mon_req), .mon_we(mon_we), .mon_addr(mon_addr), .mon_wdata(mon_wdata),
    .mon_ack(a_mon_ack), .mon_rdata(a_mon_rdata), .mon_lock(mon_lock),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_we(a_mem_we), .mem_re(a_mem_re),
    .mem_rdata(mem_rdata), .gnt_id(a_gnt_id), .busy(a_busy)
  );

  s08_bus_arbiter #(.MEM_LAT(3), .MAX_HOLD(16)) dut_b (
    .clk50(clk50), .resetin(resetin),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(b_cpu_ack), .cpu_rdata(b_cpu_rdata),
    .mon_req(mon_req), .mon_we(mon_we), .mon_addr(mon_addr), .mon_wdata(mon_wdata),
    .mon_ack(b_mon_ack), .mon_rdata(b_mon_rdata), .mon_lock(mon_lock),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we), .mem_re(b_mem_re),
    .mem_rdata(mem_rdata), .gnt_id(b_gnt_id), .busy(b_busy)
  );

  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

  task automatic do_reset();
    resetin   = 1'b0;
    cpu_req   = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mon_req   = 1'b0; mon_we = 1'b0; mon_addr = '0; mon_wdata = '0;
    mon_lock  = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk50);
    #1 resetin = 1'b1;
  endtask

  task automatic test_reset();
    resetin = 1'b0;
    cpu_req = 1'b0; mon_req = 1'b0; mon_lock = 1'b0;
    #3;
    total++;
    if ({a_mem_we, a_mem_re, a_cpu_ack, a_mon_ack, a_busy, a_gnt_id} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got we/re/cack/mack/busy/gnt=%b want 000000",
               {a_mem_we, a_mem_re, a_cpu_ack, a_mon_ack, a_busy, a_gnt_id});
    end
    total++;
    if (a_cpu_rdata !== 8'h00 || a_mon_rdata !== 8'h00) begin
      bad++;
      $display("FAIL reset_rdata: got cpu=%h mon=%h want 00 00", a_cpu_rdata, a_mon_rdata);
    end
  endtask

  task automatic test_cpu_read();
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h1B5;
    tick();  // cycle 1
    total++;
    if (a_mem_re !== 1'b1 || a_mem_we !== 1'b0 || a_mem_addr !== 10'h1B5) begin
      bad++;
      $display("FAIL rd_access: got re=%b we=%b addr=%h want 1 0 1b5", a_mem_re, a_mem_we, a_mem_addr);
    end
    tick();  // cycle 2
    mem_rdata = 8'h45;
    total++;
    if (a_mem_re !== 1'b0 || a_cpu_ack !== 1'b0) begin
      bad++;
      $display("FAIL rd_wait: got re=%b ack=%b want 0 0", a_mem_re, a_cpu_ack);
    end
    tick();  // cycle 3
    total++;
    if (a_cpu_ack !== 1'b1 || a_cpu_rdata !== 8'h45 || a_mon_ack !== 1'b0) begin
      bad++;
      $display("FAIL rd_ack: got ack=%b rdata=%h mack=%b want 1 45 0", a_cpu_ack, a_cpu_rdata, a_mon_ack);
    end
    cpu_req = 1'b0;
    mem_rdata = 8'h00;
    tick();  // cycle 4
    total++;
    if (a_cpu_ack !== 1'b0 || a_cpu_rdata !== 8'h45 || a_busy !== 1'b0) begin
      bad++;
      $display("FAIL rd_after: got ack=%b rdata=%h busy=%b want 0 45 0", a_cpu_ack, a_cpu_rdata, a_busy);
    end
  endtask

  task automatic test_tie_writes();
    logic [9:0] addrs [2];
    logic [7:0] datas [2];
    int n = 0;
    int cpu_cyc = -1;
    int mon_cyc = -1;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h080; cpu_wdata = 8'hAA;
    mon_req = 1'b1; mon_we = 1'b1; mon_addr = 10'h081; mon_wdata = 8'h55;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (a_mem_we) begin
        if (n < 2) begin addrs[n] = a_mem_addr; datas[n] = a_mem_wdata; end
        n++;
      end
      if (a_cpu_ack) begin cpu_cyc = c; cpu_req = 1'b0; end
      if (a_mon_ack) begin mon_cyc = c; mon_req = 1'b0; end
    end
    total++;
    if (n !== 2) begin
      bad++;
      $display("FAIL tie_we_count: got %0d pulses want 2", n);
    end
    if (n >= 2) begin
      total++;
      if (addrs[0] !== 10'h080 || datas[0] !== 8'hAA || addrs[1] !== 10'h081 || datas[1] !== 8'h55) begin
        bad++;
        $display("FAIL tie_order: got %h<-%h then %h<-%h want 080<-aa then 081<-55",
                 addrs[0], datas[0], addrs[1], datas[1]);
      end
    end
    total++;
    if (cpu_cyc != 3 || mon_cyc != 7) begin
      bad++;
      $display("FAIL tie_ack_cycles: got cpu=%0d mon=%0d want 3 7", cpu_cyc, mon_cyc);
    end
  endtask

  task automatic test_lock();
    logic seq [6];
    logic exp_seq [6];
    int n = 0;
    exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    do_reset();
    mon_lock = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h100; cpu_wdata = 8'h01;
    mon_req = 1'b1; mon_we = 1'b1; mon_addr = 10'h200; mon_wdata = 8'h02;
    for (int c = 0; c < 40 && n < 6; c++) begin
      tick();
      if (a_mem_we) begin seq[n] = a_gnt_id; n++; end
    end
    total++;
    if (n != 6) begin
      bad++;
      $display("FAIL lock_grants: got %0d grants within budget want 6", n);
    end
    for (int i = 0; i < n; i++) begin
      total++;
      if (seq[i] !== exp_seq[i]) begin
        bad++;
        $display("FAIL lock_seq[%0d]: got owner %b want %b", i, seq[i], exp_seq[i]);
      end
    end
    mon_lock = 1'b0; cpu_req = 1'b0; mon_req = 1'b0;
  endtask

  task automatic test_latency3();
    do_reset();
    mon_req = 1'b1; mon_we = 1'b0; mon_addr = 10'h007; mon_wdata = 8'h12;
    mem_rdata = 8'hEE;
    total++;
    if (b_busy !== 1'b0) begin
      bad++;
      $display("FAIL lat_busy0: got %b want 0", b_busy);
    end
    for (int c = 1; c <= 6; c++) begin
      tick();
      mem_rdata = (c == 4) ? 8'h3C : 8'hEE;
      total++;
      if (b_busy !== (c <= 5) || b_mon_ack !== (c == 5)) begin
        bad++;
        $display("FAIL lat_cycle%0d: got busy=%b ack=%b want %b %b", c, b_busy, b_mon_ack, (c <= 5), (c == 5));
      end
      if (c == 1) begin
        total++;
        if (b_mem_re !== 1'b1 || b_mem_we !== 1'b0 || b_mem_addr !== 10'h007 ||
            b_mem_wdata !== 8'h12 || b_gnt_id !== 1'b1) begin
          bad++;
          $display("FAIL lat_access: got re=%b we=%b addr=%h wd=%h gnt=%b want 1 0 007 12 1",
                   b_mem_re, b_mem_we, b_mem_addr, b_mem_wdata, b_gnt_id);
        end
      end
      if (c == 5) begin
        total++;
        if (b_mon_rdata !== 8'h3C) begin
          bad++;
          $display("FAIL lat_rdata: got %h want 3c", b_mon_rdata);
        end
        mon_req = 1'b0;
      end
      if (c == 6) begin
        total++;
        if (b_cpu_ack !== 1'b0 || b_cpu_rdata !== 8'h00 || b_mon_rdata !== 8'h3C) begin
          bad++;
          $display("FAIL lat_other: got cack=%b crd=%h mrd=%h want 0 00 3c", b_cpu_ack, b_cpu_rdata, b_mon_rdata);
        end
      end
    end
  endtask

  task automatic test_reset_midwrite();
    logic saw_ack = 1'b0;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h3FF; cpu_wdata = 8'h99;
    tick();  // ACCESS
    total++;
    if (a_mem_we !== 1'b1) begin
      bad++;
      $display("FAIL rst_pre: got mem_we=%b want 1", a_mem_we);
    end
    #2 resetin = 1'b0;
    #1;
    total++;
    if (a_mem_we !== 1'b0 || a_busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_async: got mem_we=%b busy=%b want 0 0", a_mem_we, a_busy);
    end
    mon_req = 1'b1; mon_we = 1'b1; mon_addr = 10'h055; mon_wdata = 8'h11;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (a_cpu_ack || a_mon_ack) saw_ack = 1'b1;
    end
    resetin = 1'b1;
    tick();
    total++;
    if (saw_ack !== 1'b0 || a_mem_we !== 1'b1 || a_gnt_id !== 1'b0 || a_mem_addr !== 10'h3FF) begin
      bad++;
      $display("FAIL rst_tie: got ack_seen=%b we=%b gnt=%b addr=%h want 0 1 0 3ff",
               saw_ack, a_mem_we, a_gnt_id, a_mem_addr);
    end
    cpu_req = 1'b0; mon_req = 1'b0;
  endtask

  task automatic test_drop_req();
    int acks = 0;
    int starts = 0;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h010;
    mem_rdata = 8'h77;
    tick();  // cycle 1
    tick();  // cycle 2, WAIT
    cpu_req = 1'b0;
    tick();  // cycle 3
    total++;
    if (a_cpu_ack !== 1'b1 || a_cpu_rdata !== 8'h77) begin
      bad++;
      $display("FAIL drop_ack: got ack=%b rdata=%h want 1 77", a_cpu_ack, a_cpu_rdata);
    end
    for (int c = 4; c <= 8; c++) begin
      tick();
      if (a_cpu_ack) acks++;
      if (a_mem_re || a_mem_we || a_busy) starts++;
    end
    total++;
    if (acks != 0 || starts != 0) begin
      bad++;
      $display("FAIL drop_idle: got extra acks=%0d active cycles=%0d want 0 0", acks, starts);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_tie_writes();
    test_lock();
    test_latency3();
    test_reset_midwrite();
    test_drop_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
